// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared external ALU: arbitrates, registers the
// winning operation, drives the ALU for one cycle and holds the result until consumed.
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_in1,
  input  logic [15:0] req0_in2,
  input  logic        req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_in1,
  input  logic [15:0] req1_in2,
  input  logic        req1_op,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output logic        alu_op,
  input  logic [15:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_carry,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_out,
  output logic        rsp_zero,
  output logic        rsp_carry,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] in1_q, in1_d;
  logic [15:0] in2_q, in2_d;
  logic        op_q, op_d;
  logic        id_q, id_d;
  logic [15:0] out_q, out_d;
  logic        zero_q, zero_d;
  logic        carry_q, carry_d;

  logic        grant;
  logic        can_accept;
  logic        accept;

  // Handshakes: a transfer happens in a cycle where valid and ready are both 1.
  // Requesters hold valid and operands until ready; the response holds until rsp_ready.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = FIXED_PRIO ? 1'b0 : ~last_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign can_accept = (state_q == IDLE) && !reset;
  assign req0_ready = can_accept && req0_valid && !grant;
  assign req1_ready = can_accept && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    op_d    = op_q;
    id_d    = id_q;
    out_d   = out_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          last_d  = grant;
          id_d    = grant;
          in1_d   = grant ? req1_in1 : req0_in1;
          in2_d   = grant ? req1_in2 : req0_in2;
          op_d    = grant ? req1_op  : req0_op;
        end
      end
      EXEC: begin
        state_d = RESP;
        out_d   = alu_out;
        zero_d  = alu_zero;
        carry_d = alu_carry;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      in1_q   <= 16'h0000;
      in2_q   <= 16'h0000;
      op_q    <= 1'b0;
      id_q    <= 1'b0;
      out_q   <= 16'h0000;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      op_q    <= op_d;
      id_q    <= id_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign alu_in1   = in1_q;
  assign alu_in2   = in2_q;
  assign alu_op    = op_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_out   = out_q;
  assign rsp_zero  = zero_q;
  assign rsp_carry = carry_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin and fixed-priority instances share stimulus,
// each drives its own behavioural ALU.
module tb_alu_arbiter;

  localparam int W = 19;  // {id, zero, carry, out}

  logic clk = 1'b0;
  logic reset;
  logic req0_valid, req1_valid, req0_op, req1_op, rsp_ready;
  logic [15:0] req0_in1, req0_in2, req1_in1, req1_in2;

  logic req0_ready, req1_ready, alu_op, alu_zero, alu_carry;
  logic rsp_valid, rsp_id, rsp_zero, rsp_carry;
  logic [15:0] alu_in1, alu_in2, alu_out, rsp_out;
  logic [1:0] dbg_state;
  logic [16:0] alu_sum;

  logic f_req0_ready, f_req1_ready, f_alu_op, f_alu_zero, f_alu_carry;
  logic f_rsp_valid, f_rsp_id, f_rsp_zero, f_rsp_carry;
  logic [15:0] f_alu_in1, f_alu_in2, f_alu_out, f_rsp_out;
  logic [1:0] f_dbg_state;
  logic [16:0] f_alu_sum;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  int   m_busy;
  logic m_last, e0, e1, ev, acc0, acc1;

  typedef struct {
    logic        id;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic        zero;
    logic        carry;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  assign alu_sum   = {1'b0, alu_in1} + {1'b0, alu_in2};
  assign alu_out   = alu_op ? ~(alu_in1 & alu_in2) : alu_sum[15:0];
  assign alu_carry = alu_op ? 1'b0 : alu_sum[16];
  assign alu_zero  = (alu_out == 16'h0000);

  assign f_alu_sum   = {1'b0, f_alu_in1} + {1'b0, f_alu_in2};
  assign f_alu_out   = f_alu_op ? ~(f_alu_in1 & f_alu_in2) : f_alu_sum[15:0];
  assign f_alu_carry = f_alu_op ? 1'b0 : f_alu_sum[16];
  assign f_alu_zero  = (f_alu_out == 16'h0000);

  alu_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1),
    .req0_in2(req0_in2), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1),
    .req1_in2(req1_in2), .req1_op(req1_op),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .dbg_state(dbg_state)
  );

  alu_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_in1(req0_in1),
    .req0_in2(req0_in2), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_in1(req1_in1),
    .req1_in2(req1_in2), .req1_op(req1_op),
    .alu_in1(f_alu_in1), .alu_in2(f_alu_in2), .alu_op(f_alu_op),
    .alu_out(f_alu_out), .alu_zero(f_alu_zero), .alu_carry(f_alu_carry),
    .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(f_rsp_id),
    .rsp_out(f_rsp_out), .rsp_zero(f_rsp_zero), .rsp_carry(f_rsp_carry),
    .dbg_state(f_dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_op = 1'b0; req0_in1 = 16'h0; req0_in2 = 16'h0;
    req1_valid = 1'b0; req1_op = 1'b0; req1_in1 = 16'h0; req1_in2 = 16'h0;
    rsp_ready  = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("reset_ready0", req0_ready, 0);
    check("reset_ready1", req1_ready, 0);
    tick();
    reset = 1'b0;
    idle_inputs();
  endtask

  function automatic logic [W-1:0] model_op(input logic id, input logic op,
                                            input logic [15:0] a, input logic [15:0] b);
    int unsigned s;
    logic [15:0] r;
    logic c;
    if (op) begin
      r = ~(a & b);
      c = 1'b0;
    end else begin
      s = int'(a) + int'(b);
      r = s[15:0];
      c = (s > 32'd65535);
    end
    return {id, (r == 16'h0000), c, r};
  endfunction

  function automatic logic [15:0] rand_operand();
    case ($urandom_range(0, 4))
      0: return 16'hFFFF;
      1: return 16'h0000;
      2: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 16'hFFFF, 16'h00FF, 16'hFF00, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0};

    // Reset state
    do_reset();
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp", {rsp_id, rsp_zero, rsp_carry, rsp_out}, 0);
    check("rst_alu", {alu_op, alu_in1, alu_in2}, 0);
    check("rst_state", dbg_state, 0);
    check("rst_fp_rsp_valid", f_rsp_valid, 0);
    check("rst_fp_state", f_dbg_state, 0);

    // Single-operation vectors
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      if (vecs[i].id) begin
        req1_valid = 1'b1; req1_op = vecs[i].op; req1_in1 = vecs[i].a; req1_in2 = vecs[i].b;
      end else begin
        req0_valid = 1'b1; req0_op = vecs[i].op; req0_in1 = vecs[i].a; req0_in2 = vecs[i].b;
      end
      #1;
      check("vec_ready", {req1_ready, req0_ready}, vecs[i].id ? 2'b10 : 2'b01);
      tick();
      idle_inputs();
      #1;
      check("vec_exec_rsp_valid", rsp_valid, 0);
      check("vec_alu_regs", {alu_op, alu_in1, alu_in2}, {vecs[i].op, vecs[i].a, vecs[i].b});
      tick();
      check("vec_rsp_valid", rsp_valid, 1);
      check("vec_rsp", {rsp_id, rsp_zero, rsp_carry, rsp_out},
            {vecs[i].id, vecs[i].zero, vecs[i].carry, vecs[i].out});
      tick();
    end

    // Both valid continuously: round-robin alternates, fixed priority always req0
    do_reset();
    req0_valid = 1'b1; req0_op = 1'b0; req0_in1 = 16'h0001; req0_in2 = 16'h0002;
    req1_valid = 1'b1; req1_op = 1'b1; req1_in1 = 16'hFFFF; req1_in2 = 16'h00FF;
    for (int c = 0; c < 12; c++) begin
      #1;
      check("rr_ready0", req0_ready, (c % 3 == 0) && ((c / 3) % 2 == 0));
      check("rr_ready1", req1_ready, (c % 3 == 0) && ((c / 3) % 2 == 1));
      check("rr_rsp_valid", rsp_valid, c % 3 == 2);
      check("fp_ready0", f_req0_ready, c % 3 == 0);
      check("fp_ready1", f_req1_ready, 0);
      check("fp_rsp_valid", f_rsp_valid, c % 3 == 2);
      if (c % 3 == 2) begin
        check("rr_rsp_id", rsp_id, (c / 3) % 2);
        check("rr_rsp_out", rsp_out, ((c / 3) % 2 == 1) ? 16'hFF00 : 16'h0003);
        check("fp_rsp", {f_rsp_id, f_rsp_out}, {1'b0, 16'h0003});
      end
      tick();
    end

    // Response stall for 5 cycles
    do_reset();
    req0_valid = 1'b1; req0_op = 1'b0; req0_in1 = 16'h00FF; req0_in2 = 16'h0001;
    rsp_ready = 1'b0;
    #1;
    check("stall_accept", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    tick();
    req0_valid = 1'b1; req0_in1 = 16'h5555;
    req1_valid = 1'b1; req1_in1 = 16'hAAAA;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rsp", {rsp_id, rsp_zero, rsp_carry, rsp_out}, {3'b000, 16'h0100});
      check("stall_readies", {req1_ready, req0_ready}, 2'b00);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("stall_release_valid", rsp_valid, 1);
    check("stall_release_readies", {req1_ready, req0_ready}, 2'b00);
    tick();
    check("stall_idle_state", dbg_state, 0);
    check("stall_idle_rsp_valid", rsp_valid, 0);
    check("stall_idle_rr_grant", {req1_ready, req0_ready}, 2'b10);

    // Reset while in EXEC abandons the operation and restores req0 tie priority
    do_reset();
    req0_valid = 1'b1; req0_op = 1'b0; req0_in1 = 16'h1111; req0_in2 = 16'h2222;
    #1;
    check("rex_accept", req0_ready, 1);
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rex_rsp_valid", rsp_valid, 0);
    check("rex_state", dbg_state, 0);
    check("rex_rsp_out", rsp_out, 16'h0000);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("rex_tie", {req1_ready, req0_ready}, 2'b01);
    tick();
    idle_inputs();
    tick();
    check("rex_next_rsp", {rsp_valid, rsp_id}, 2'b10);
    tick();

    // Randomized traffic against the transaction-level model
    do_reset();
    exp_q.delete();
    m_busy = 0;
    m_last = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!req0_valid && $urandom_range(0, 2) != 0) begin
        req0_valid = 1'b1; req0_op = 1'($urandom_range(0, 1));
        req0_in1 = rand_operand(); req0_in2 = rand_operand();
      end
      if (!req1_valid && $urandom_range(0, 2) != 0) begin
        req1_valid = 1'b1; req1_op = 1'($urandom_range(0, 1));
        req1_in1 = rand_operand(); req1_in2 = rand_operand();
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      e0 = 1'b0;
      e1 = 1'b0;
      if (exp_q.size() == 0) begin
        if (req0_valid && req1_valid) begin
          if (m_last) e0 = 1'b1;
          else e1 = 1'b1;
        end else if (req0_valid) e0 = 1'b1;
        else if (req1_valid) e1 = 1'b1;
      end
      ev = (exp_q.size() != 0) && (m_busy == 0);
      check("rnd_readies", {req1_ready, req0_ready}, {e1, e0});
      check("rnd_rsp_valid", rsp_valid, ev);
      if (ev) check("rnd_rsp", {rsp_id, rsp_zero, rsp_carry, rsp_out}, exp_q[0]);
      if (ev && rsp_ready) void'(exp_q.pop_front());
      if (m_busy > 0) m_busy--;
      if (e0) exp_q.push_back(model_op(1'b0, req0_op, req0_in1, req0_in2));
      if (e1) exp_q.push_back(model_op(1'b1, req1_op, req1_in1, req1_in2));
      if (e0 || e1) begin
        m_busy = 1;
        m_last = e1;
      end
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      tick();
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0, arbitration mode: 0 = round-robin, 1 = requester 0 always wins.
REQ-002 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have req0_valid / req1_valid  input  1 each  requester k has an operation pending.
REQ-005 SHALL have req0_ready / req1_ready  output  1 each  requester k's operation is accepted this cycle.
REQ-006 SHALL have req0_in1, req0_in2, req1_in1, req1_in2  input  16 each  operands.
REQ-007 SHALL have req0_op / req1_op  input  1 each  operation select: 0 = add, 1 = nand.
REQ-008 SHALL have alu_in1, alu_in2  output  16 each  operands to the shared ALU.
REQ-009 SHALL have alu_op  output  1  operation select to the shared ALU.
REQ-010 SHALL have alu_out  input  16  ALU result, combinational from alu_in1/alu_in2/alu_op.
REQ-011 SHALL have alu_zero, alu_carry  input  1 each  ALU flags; carry is 0 for nand.
REQ-012 SHALL have rsp_valid  output  1  response pending.
REQ-013 SHALL have rsp_ready  input  1  consumer accepts the response.
REQ-014 SHALL have rsp_id  output  1  index of the requester that issued the operation.
REQ-015 SHALL have rsp_out  output  16  result.
REQ-016 SHALL have rsp_zero, rsp_carry  output  1 each  flags for the result.

Function
REQ-017 SHALL implement FSM states IDLE, EXEC, RESP; transitions: IDLE->EXEC on accept; EXEC->RESP unconditionally; RESP->IDLE when rsp_ready=1.
REQ-018 SHALL assert reqK_ready only in IDLE, only for the granted requester, and at most one ready per cycle; accept = reqK_valid & reqK_ready.
REQ-019 SHALL, in IDLE, grant by arbitration: if only one valid, grant it; if both valid, FIXED_PRIO=1 grants req0; FIXED_PRIO=0 grants the requester not granted last.
REQ-020 SHALL, on accept, register the grantee's in1, in2, op and id; alu_in1, alu_in2 and alu_op are driven only from these registers.
REQ-021 SHALL, in EXEC, capture alu_out, alu_zero and alu_carry into the rsp_out, rsp_zero and rsp_carry registers.
REQ-022 SHALL assert rsp_valid in RESP only; with an accept in cycle N, rsp_valid=1 in cycle N+2.
REQ-023 SHALL hold rsp_id, rsp_out, rsp_zero and rsp_carry stable while rsp_valid=1 and rsp_ready=0.
REQ-024 SHALL accept no new request while in EXEC or RESP; maximum throughput is one operation per 3 cycles.
REQ-025 SHALL update the last-granted pointer only on accept.
REQ-026 SHALL leave an unaccepted request pending without loss; the requester holds valid and operands until ready.

Reset
REQ-027 SHALL, while reset=1 at a clock edge, set state IDLE and last-granted=1 (req0 wins first tie).
REQ-028 SHALL, on reset, clear the operand registers and alu_op to 0, and clear rsp_valid, rsp_id, rsp_out, rsp_zero and rsp_carry to 0.
REQ-029 SHALL force req0_ready=req1_ready=0 in any cycle where reset=1.
REQ-030 SHALL, on reset in EXEC or RESP, abandon the in-flight operation with no response produced.

Verification
REQ-031 SHALL cover: req0 add 0x0001+0xFFFF accepted cycle N -> cycle N+2 rsp_valid=1, rsp_id=0, rsp_out=0x0000, rsp_zero=1, rsp_carry=1.
REQ-032 SHALL cover: req1 nand 0xFFFF,0x00FF -> rsp_out=0xFF00, rsp_zero=0, rsp_carry=0, rsp_id=1.
REQ-033 SHALL cover: both valid continuously after reset with FIXED_PRIO=0 and rsp_ready=1 -> rsp_id sequence 0,1,0,1, one accept every 3 cycles.
REQ-034 SHALL cover: FIXED_PRIO=1 with both valid continuously -> every response has rsp_id=0, req1_ready never asserted.
REQ-035 SHALL cover: rsp_ready=0 for 5 cycles in RESP -> outputs unchanged, no readies asserted; rsp_ready=1 -> IDLE next cycle.
REQ-036 SHALL cover: reset=1 for 1 cycle while in EXEC -> next cycle rsp_valid=0, state IDLE, rsp_out=0x0000, req0 wins the next tie.
